// File: rtl/flac_pkg.sv
// Shared FLAC decoder-path definitions: stream/sample widths, Rice default
// parameter and the Rice FSM state encoding.
package flac_pkg;

   localparam int RICE_PARAM_DEF = 4;
   localparam int SAMPLE_W       = 16;
   localparam int WORD_W         = 16;
   localparam int BITCNT_W       = $clog2(WORD_W + 1);

   localparam logic [0:0] ST_UNARY = 1'b0;
   localparam logic [0:0] ST_REM   = 1'b1;

   typedef logic [WORD_W-1:0]   word_t;
   typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/rice_decoder_if.sv
// Stream-in / sample-out bundle between the subframe parser, the Rice
// decoder and the predictor restoration stage.
interface rice_decoder_if;
   import flac_pkg::*;

   word_t   iData;
   logic    iValid;
   logic    oReady;
   sample_t oSample;
   logic    oValid;
   logic    oError;

   modport master (
      output iData, iValid,
      input  oReady, oSample, oValid, oError
   );

   modport slave (
      input  iData, iValid,
      output oReady, oSample, oValid, oError
   );

endinterface

// File: rtl/rice_bit_buffer.sv
// Word-to-bit serializer: loads a 16-bit stream word and hands out one bit
// per consume, MSB first, re-arming ready so consecutive words are gapless.
module rice_bit_buffer
   import flac_pkg::*;
(
   input  logic  iClock,
   input  logic  iReset,
   input  word_t data,
   input  logic  valid,
   output logic  ready,
   output logic  bit_out,
   output logic  bit_valid,
   input  logic  consume
);

   word_t               shreg;
   logic [BITCNT_W-1:0] bits_left;
   logic                take;

   assign bit_valid = (bits_left != '0);
   assign bit_out   = shreg[WORD_W-1];
   // Accept the next word in the same cycle the last buffered bit is used.
   assign ready     = (bits_left == '0) ||
                      ((bits_left == BITCNT_W'(1)) && consume);
   assign take      = valid && ready;

   always_ff @(posedge iClock) begin
      if (iReset) begin
         shreg     <= '0;
         bits_left <= '0;
      end else if (take) begin
         shreg     <= data;
         bits_left <= BITCNT_W'(WORD_W);
      end else if (consume && bit_valid) begin
         shreg     <= {shreg[WORD_W-2:0], 1'b0};
         bits_left <= bits_left - BITCNT_W'(1);
      end
   end

endmodule

// File: rtl/rice_decoder.sv
// Bit-serial Rice decoder: one stream bit per clock, rebuilds signed 16-bit
// residuals from quotient/remainder and flags quotient overflow.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_UNARY | counting leading zeros (quotient); a 1 is the stop bit
//   ST_REM   | shifting in RICE_PARAM remainder bits; last one emits
module rice_decoder
   import flac_pkg::*;
#(
   parameter int RICE_PARAM = RICE_PARAM_DEF
) (
   input logic           iClock,
   input logic           iReset,
   rice_decoder_if.slave bus
);

   localparam int              QW     = SAMPLE_W - RICE_PARAM;
   localparam logic [QW-1:0]   Q_MAX  = '1;
   localparam int              RW     = (RICE_PARAM > 0) ? RICE_PARAM : 1;
   localparam logic [SAMPLE_W-1:0] R_MASK =
      SAMPLE_W'((32'd1 << RICE_PARAM) - 32'd1);

   logic                bit_in;
   logic                bit_valid;
   logic                consume;

   logic [0:0]          state, state_nxt;
   logic [QW-1:0]       quot, quot_nxt;
   logic [RW-1:0]       rem, rem_nxt;
   logic [BITCNT_W-1:0] rem_left, rem_left_nxt;
   logic                done;
   logic                ovf;
   sample_t             u_full;
   sample_t             mapped;

   // The FSM always takes a bit whenever one is buffered.
   assign consume = bit_valid;

   rice_bit_buffer u_buf (
      .iClock    (iClock),
      .iReset    (iReset),
      .data      (bus.iData),
      .valid     (bus.iValid),
      .ready     (bus.oReady),
      .bit_out   (bit_in),
      .bit_valid (bit_valid),
      .consume   (consume)
   );

   always_comb begin
      state_nxt    = state;
      quot_nxt     = quot;
      rem_nxt      = rem;
      rem_left_nxt = rem_left;
      done         = 1'b0;
      ovf          = 1'b0;
      if (bit_valid) begin
         case (state)
            ST_UNARY: begin
               if (!bit_in) begin
                  if (quot == Q_MAX) begin
                     ovf      = 1'b1;
                     quot_nxt = '0;
                  end else begin
                     quot_nxt = quot + QW'(1);
                  end
               end else begin
                  rem_nxt = '0;
                  if (RICE_PARAM == 0) begin
                     done = 1'b1;
                  end else begin
                     state_nxt    = ST_REM;
                     rem_left_nxt = BITCNT_W'(RICE_PARAM);
                  end
               end
            end
            ST_REM: begin
               rem_nxt = RW'({rem, bit_in});
               if (rem_left == BITCNT_W'(1)) begin
                  done      = 1'b1;
                  state_nxt = ST_UNARY;
               end else begin
                  rem_left_nxt = rem_left - BITCNT_W'(1);
               end
            end
            default: state_nxt = ST_UNARY;
         endcase
         if (done) begin
            quot_nxt = '0;
         end
      end
   end

   // Quotient is stable through the remainder bits, so the completing
   // cycle can assemble u from the current quotient and the new remainder.
   assign u_full = (SAMPLE_W'(quot) << RICE_PARAM) | (SAMPLE_W'(rem_nxt) & R_MASK);
   assign mapped = u_full[0] ? ~{1'b0, u_full[SAMPLE_W-1:1]}
                             :  {1'b0, u_full[SAMPLE_W-1:1]};

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state       <= ST_UNARY;
         quot        <= '0;
         rem         <= '0;
         rem_left    <= '0;
         bus.oSample <= '0;
         bus.oValid  <= 1'b0;
         bus.oError  <= 1'b0;
      end else begin
         state      <= state_nxt;
         quot       <= quot_nxt;
         rem        <= rem_nxt;
         rem_left   <= rem_left_nxt;
         bus.oValid <= done;
         bus.oError <= ovf;
         if (done) begin
            bus.oSample <= mapped;
         end
      end
   end

endmodule

// File: tb/tb_rice_decoder.sv
// Self-checking bench for rice_decoder: a sample-level Rice encoder model
// builds the bitstream and the expected sample/error events with timing.
module tb_rice_decoder;
   import flac_pkg::*;

   localparam int K = 4;

   typedef struct packed {
      int          endbit;
      logic        err;
      logic [15:0] val;
   } exp_t;

   typedef struct packed {
      int          cyc;
      logic        err;
      logic [15:0] val;
   } obs_t;

   logic clk;
   logic iReset;
   int   cyc;
   int   n_chk;
   int   n_bad;

   bit   bitq[$];
   exp_t evq[$];
   obs_t obs[$];
   int   acc[$];

   rice_decoder_if bus ();

   rice_decoder #(.RICE_PARAM(K)) dut (
      .iClock (clk),
      .iReset (iReset),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.oValid || bus.oError)
         obs.push_back('{cyc, bus.oError, bus.oSample});
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      iReset     = 1'b1;
      bus.iValid = 1'b0;
      bus.iData  = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst oValid", 32'(bus.oValid), 32'd0);
      chk("rst oError", 32'(bus.oError), 32'd0);
      chk("rst oSample", 32'(bus.oSample), 32'd0);
      chk("rst oReady", 32'(bus.oReady), 32'd1);
      iReset = 1'b0;
      obs.delete();
      acc.delete();
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send_word(input logic [15:0] w);
      int n;
      n          = 0;
      bus.iData  = w;
      bus.iValid = 1'b1;
      #1;
      while (!bus.oReady && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 200) chk("ready timeout", 32'd0, 32'd1);
      acc.push_back(cyc);
      @(negedge clk);
      bus.iValid = 1'b0;
   endtask

   task automatic enc_sample(input int s);
      int u;
      int q;
      u = (s >= 0) ? 2 * s : -2 * s - 1;
      q = u >> K;
      repeat (q) bitq.push_back(1'b0);
      bitq.push_back(1'b1);
      for (int i = K - 1; i >= 0; i--) bitq.push_back(bit'((u >> i) & 1));
      evq.push_back('{bitq.size() - 1, 1'b0, 16'(s)});
   endtask

   task automatic enc_zeros(input int n);
      repeat (n) bitq.push_back(1'b0);
   endtask

   task automatic run_stream(input string name, input int gap_at, input int gap_len);
      int          nw;
      int          nmin;
      logic [15:0] w;
      while (bitq.size() % 16 != 0) bitq.push_back(1'b0);
      nw = bitq.size() / 16;
      for (int wi = 0; wi < nw; wi++) begin
         for (int b = 0; b < 16; b++) w[15-b] = bitq[wi*16 + b];
         if (wi == gap_at) begin
            while (cyc < acc[acc.size()-1] + 16) @(negedge clk);
            repeat (gap_len) @(negedge clk);
         end
         send_word(w);
      end
      repeat (24) @(negedge clk);
      for (int wi = 1; wi < nw; wi++)
         chk({name, " accept spacing"}, 32'(acc[wi] - acc[wi-1]),
             32'((wi == gap_at) ? 16 + gap_len : 16));
      chk({name, " count"}, 32'(obs.size()), 32'(evq.size()));
      nmin = (obs.size() < evq.size()) ? obs.size() : evq.size();
      for (int i = 0; i < nmin; i++) begin
         chk({name, " err"}, 32'(obs[i].err), 32'(evq[i].err));
         if (!evq[i].err) chk({name, " val"}, 32'(obs[i].val), 32'(evq[i].val));
         chk({name, " cyc"}, 32'(obs[i].cyc),
             32'(acc[evq[i].endbit / 16] + 2 + evq[i].endbit % 16));
      end
      bitq.delete();
      evq.delete();
      do_reset();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int u;
      int c;
      n_chk      = 0;
      n_bad      = 0;
      cyc        = 0;
      iReset     = 1'b1;
      bus.iValid = 1'b0;
      bus.iData  = '0;
      do_reset();

      // 3, -1, 8 fill 16'hB450 exactly; a second word checks re-arm timing.
      enc_sample(3);
      enc_sample(-1);
      enc_sample(8);
      enc_sample(5);
      run_stream("basic", -1, 0);

      enc_sample(100);
      run_stream("span", 1, 5);

      enc_sample(-32768);
      enc_sample(32767);
      enc_sample(0);
      run_stream("extreme", -1, 0);

      enc_zeros(4096);
      evq.push_back('{bitq.size() - 1, 1'b1, 16'h0});
      enc_sample(1);
      run_stream("overflow", -1, 0);

      // Partial symbol (quotient 2, stop bit seen) is cut by reset.
      send_word(16'hB100);
      c = acc[0];
      while (cyc < c + 9) @(negedge clk);
      iReset = 1'b1;
      @(negedge clk);
      chk("midrst oValid", 32'(bus.oValid), 32'd0);
      chk("midrst oError", 32'(bus.oError), 32'd0);
      chk("midrst oSample", 32'(bus.oSample), 32'd0);
      chk("midrst oReady", 32'(bus.oReady), 32'd1);
      iReset = 1'b0;
      chk("midrst prior count", 32'(obs.size()), 32'd1);
      if (obs.size() > 0) chk("midrst prior val", 32'(obs[0].val), 32'd3);
      do_reset();
      enc_sample(5);
      enc_sample(-7);
      run_stream("after reset", -1, 0);

      forever begin
         s = int'($urandom_range(0, 600)) - 300;
         u = (s >= 0) ? 2 * s : -2 * s - 1;
         if (bitq.size() + (u >> K) + 1 + K > 1024) break;
         enc_sample(s);
      end
      enc_zeros(1024 - bitq.size());
      run_stream("b2b", -1, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
